// File: rtl/csr_test_sequencer.sv
// csr_test_sequencer
//
// Autonomous master for the memory-checker CSR slave. Accepts one test
// command (three parameter words), writes them to CSR addresses 1..3, sets
// the start bit (address 0), polls the done flag (address 4) every
// POLL_GAP idle cycles, burst-reads the ten result words (addresses 5..14)
// and presents them as one result record.
//
// Optional feature macro: CSR_SEQ_TIMEOUT_EN
//   defined   : a saturating 16-bit poll counter aborts the test after
//               TIMEOUT_POLLS unsuccessful done-flag reads (res_timeout_o=1,
//               res_data_o all zero).
//   undefined : polling never gives up; res_timeout_o is tied low.
//
// Handshakes (valid/ready): a transfer happens on a rising clk_sys_i edge
// where both valid and ready are high. Valid, once raised by the producer,
// is held with stable data until that transfer. cmd: cmd_valid_i/cmd_ready_o
// (host produces). res: res_valid_o/res_ready_i (sequencer produces).
//
// Ports:
//   clk_sys_i        system clock
//   rst_i            asynchronous reset, active high
//   cmd_valid_i      test command valid
//   cmd_ready_o      high only in IDLE
//   cmd_param_i      [3:1][31:0] parameter words for CSR addresses 3..1
//   avm_read_o       CSR read strobe
//   avm_write_o      CSR write strobe
//   avm_address_o    CSR word address (0 when no strobe)
//   avm_writedata_o  CSR write data (0 when no write)
//   avm_readdata_i   CSR read data, valid one cycle after avm_read_o
//   res_valid_o      result record valid, held until res_ready_i
//   res_ready_i      result consumer ready
//   res_data_o       [9:0][31:0] result words, index i = CSR address 5+i
//   res_timeout_o    record was aborted by poll timeout
//   busy_o           high in every state except IDLE

module csr_test_sequencer #(
  parameter int POLL_GAP      = 16,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic              clk_sys_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:1][31:0]  cmd_param_i,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [3:0]        avm_address_o,
  output logic [31:0]       avm_writedata_o,
  input  logic [31:0]       avm_readdata_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [9:0][31:0]  res_data_o,
  output logic              res_timeout_o,
  output logic              busy_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_PARAM  = 4'd1,
    S_WR_START  = 4'd2,
    S_POLL_WAIT = 4'd3,
    S_POLL_RD   = 4'd4,
    S_POLL_CHK  = 4'd5,
    S_RD_RES    = 4'd6,
    S_RD_LAST   = 4'd7,
    S_RESULT    = 4'd8
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_t state_q;
  state_t state_d;

  logic [3:1][31:0] param_q;
  logic [1:0]       wr_cnt_q;
  logic [15:0]      gap_cnt_q;
  logic [3:0]       rd_idx_q;
  logic [9:0][31:0] res_data_q;
  logic             timeout_hit;

`ifdef CSR_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_POLLS = 16'(TIMEOUT_POLLS);
  logic [15:0] poll_cnt_q;
  logic        res_timeout_q;

  // poll_cnt_q already includes the read being checked this cycle.
  assign timeout_hit   = (poll_cnt_q >= TO_POLLS);
  assign res_timeout_o = res_timeout_q;
`else
  logic [15:0] timeout_unused;
  assign timeout_unused = 16'(TIMEOUT_POLLS);
  assign timeout_hit    = 1'b0;
  assign res_timeout_o  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cmd_valid_i) state_d = S_WR_PARAM;
      S_WR_PARAM:  if (wr_cnt_q == 2'd2) state_d = S_WR_START;
      S_WR_START:  state_d = S_POLL_WAIT;
      S_POLL_WAIT: if (gap_cnt_q == GAP_LAST) state_d = S_POLL_RD;
      S_POLL_RD:   state_d = S_POLL_CHK;
      S_POLL_CHK: begin
        if (avm_readdata_i[0]) state_d = S_RD_RES;
        else if (timeout_hit)  state_d = S_RESULT;
        else                   state_d = S_POLL_WAIT;
      end
      S_RD_RES:    if (rd_idx_q == 4'd9) state_d = S_RD_LAST;
      S_RD_LAST:   state_d = S_RESULT;
      S_RESULT:    if (res_ready_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs, decoded purely from state and counters so that
  // a reset drops every strobe immediately.
  always_comb begin
    avm_read_o      = 1'b0;
    avm_write_o     = 1'b0;
    avm_address_o   = 4'd0;
    avm_writedata_o = 32'd0;
    case (state_q)
      S_WR_PARAM: begin
        avm_write_o   = 1'b1;
        avm_address_o = {2'b00, wr_cnt_q} + 4'd1;
        case (wr_cnt_q)
          2'd0:    avm_writedata_o = param_q[1];
          2'd1:    avm_writedata_o = param_q[2];
          default: avm_writedata_o = param_q[3];
        endcase
      end
      S_WR_START: begin
        avm_write_o     = 1'b1;
        avm_writedata_o = 32'h1;
      end
      S_POLL_RD: begin
        avm_read_o    = 1'b1;
        avm_address_o = 4'd4;
      end
      S_RD_RES: begin
        avm_read_o    = 1'b1;
        avm_address_o = 4'd5 + rd_idx_q;
      end
      default: ;
    endcase
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = (state_q == S_RESULT);
  assign res_data_o  = res_data_q;

  // Datapath: parameter latch, sub-state counters and result capture.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      param_q       <= '0;
      wr_cnt_q      <= 2'd0;
      gap_cnt_q     <= 16'd0;
      rd_idx_q      <= 4'd0;
      res_data_q    <= '0;
`ifdef CSR_SEQ_TIMEOUT_EN
      poll_cnt_q    <= 16'd0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            param_q       <= cmd_param_i;
            res_data_q    <= '0;
            wr_cnt_q      <= 2'd0;
            gap_cnt_q     <= 16'd0;
            rd_idx_q      <= 4'd0;
`ifdef CSR_SEQ_TIMEOUT_EN
            poll_cnt_q    <= 16'd0;
            res_timeout_q <= 1'b0;
`endif
          end
        end
        S_WR_PARAM: begin
          wr_cnt_q <= (wr_cnt_q == 2'd2) ? 2'd0 : wr_cnt_q + 2'd1;
        end
        S_POLL_WAIT: begin
          gap_cnt_q <= (gap_cnt_q == GAP_LAST) ? 16'd0 : gap_cnt_q + 16'd1;
        end
        S_POLL_RD: begin
`ifdef CSR_SEQ_TIMEOUT_EN
          if (poll_cnt_q != 16'hFFFF) poll_cnt_q <= poll_cnt_q + 16'd1;
`endif
        end
        S_POLL_CHK: begin
`ifdef CSR_SEQ_TIMEOUT_EN
          if (!avm_readdata_i[0] && timeout_hit) res_timeout_q <= 1'b1;
`endif
        end
        S_RD_RES: begin
          // Read data lags the strobe by one cycle: the word for the read
          // issued at index k-1 is captured while index k is being issued.
          if (rd_idx_q != 4'd0) res_data_q[rd_idx_q - 4'd1] <= avm_readdata_i;
          rd_idx_q <= (rd_idx_q == 4'd9) ? 4'd0 : rd_idx_q + 4'd1;
        end
        S_RD_LAST: begin
          res_data_q[9] <= avm_readdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_test_sequencer.sv
// tb_csr_test_sequencer
//
// Directed bench for csr_test_sequencer with POLL_GAP=4, TIMEOUT_POLLS=4.
// A behavioural CSR slave answers reads one cycle later. The driver pushes
// every expected bus cycle (with its cycle number) and every expected
// result record into queues; a negedge monitor pops and compares whenever
// the DUT strobes the bus or presents a record.
// Cycle labels: the cycle following the k-th rising edge is cycle k.

module tb_csr_test_sequencer;

  localparam int G  = 4;
  localparam int TP = 4;
  localparam int BW = 69;   // {wr, addr[3:0], data[31:0], cycle[31:0]}
  localparam int RW = 353;  // {timeout, data[319:0], cycle[31:0]}

  logic             clk_sys_i = 1'b0;
  logic             rst_i     = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [3:1][31:0] cmd_param_i = '0;
  logic             avm_read_o;
  logic             avm_write_o;
  logic [3:0]       avm_address_o;
  logic [31:0]      avm_writedata_o;
  logic [31:0]      avm_readdata_i = 32'h0;
  logic             res_valid_o;
  logic             res_ready_i = 1'b0;
  logic [9:0][31:0] res_data_o;
  logic             res_timeout_o;
  logic             busy_o;

  csr_test_sequencer #(.POLL_GAP(G), .TIMEOUT_POLLS(TP)) dut (
    .clk_sys_i       (clk_sys_i),
    .rst_i           (rst_i),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_param_i     (cmd_param_i),
    .avm_read_o      (avm_read_o),
    .avm_write_o     (avm_write_o),
    .avm_address_o   (avm_address_o),
    .avm_writedata_o (avm_writedata_o),
    .avm_readdata_i  (avm_readdata_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_data_o      (res_data_o),
    .res_timeout_o   (res_timeout_o),
    .busy_o          (busy_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk_sys_i = ~clk_sys_i;

  int cyc = 0;
  always @(posedge clk_sys_i) cyc <= cyc + 1;

  // ---------------- CSR slave model ----------------
  int          done_at_cfg = 0;   // 0 = never report done
  logic [31:0] base_cfg    = 32'h0;
  int          poll_seen   = 0;

  always @(posedge clk_sys_i) begin
    if (avm_write_o && avm_address_o == 4'd0) poll_seen <= 0;
    if (avm_read_o) begin
      if (avm_address_o == 4'd4) begin
        poll_seen <= poll_seen + 1;
        avm_readdata_i <= (done_at_cfg != 0 && poll_seen + 1 == done_at_cfg)
                          ? 32'h0000_0001 : 32'hFFFF_FFFE;
      end else begin
        avm_readdata_i <= base_cfg + 32'(avm_address_o) - 32'd5;
      end
    end else begin
      avm_readdata_i <= 32'hDEAD_BEE0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] bus_q[$];
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [BW-1:0] bus_e(input bit wr, input logic [3:0] a,
                                          input logic [31:0] d, input int c);
    return {wr, a, d, 32'(c)};
  endfunction

  // ---------------- monitor ----------------
  logic             prev_valid = 1'b0;
  bit               hs_pend    = 1'b0;
  logic [319:0]     held       = '0;
  logic [BW-1:0]    be;
  logic [RW-1:0]    re;

  always @(negedge clk_sys_i) begin
    if (rst_i) begin
      prev_valid = 1'b0;
      hs_pend    = 1'b0;
    end else begin
      if (hs_pend) begin
        chk(cmd_ready_o == 1'b1, "ready_after_handshake", 64'(cmd_ready_o), 64'd1);
        chk(res_valid_o == 1'b0, "valid_drop_after_handshake", 64'(res_valid_o), 64'd0);
        hs_pend = 1'b0;
      end
      chk(!(avm_read_o && avm_write_o), "strobe_exclusive",
          64'({avm_read_o, avm_write_o}), 64'd0);
      if (avm_read_o || avm_write_o) begin
        if (bus_q.size() == 0) begin
          chk(1'b0, "bus_unexpected", 64'({avm_write_o, avm_address_o, avm_writedata_o}), 64'd0);
        end else begin
          be = bus_q.pop_front();
          chk({avm_write_o, avm_address_o, avm_writedata_o} == be[68:32], "bus_txn",
              64'({avm_write_o, avm_address_o, avm_writedata_o}), 64'(be[68:32]));
          chk(32'(cyc) == be[31:0], "bus_cycle", 64'(cyc), 64'(be[31:0]));
        end
      end else begin
        chk(avm_address_o == 4'd0 && avm_writedata_o == 32'd0, "idle_bus_zero",
            64'({avm_address_o, avm_writedata_o}), 64'd0);
      end
      if (res_valid_o) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "res_unexpected", 64'(res_data_o[0]), 64'd0);
          end else begin
            re = exp_q.pop_front();
            chk(32'(cyc) == re[31:0], "res_valid_cycle", 64'(cyc), 64'(re[31:0]));
            chk(res_timeout_o == re[352], "res_timeout", 64'(res_timeout_o), 64'(re[352]));
            for (int i = 0; i < 10; i++)
              chk(res_data_o[i] == re[32+32*i +: 32], $sformatf("res_word%0d", i),
                  64'(res_data_o[i]), 64'(re[32+32*i +: 32]));
          end
          held = res_data_o;
        end else begin
          chk(res_data_o == held, "res_stable", 64'(res_data_o[0]), 64'(held[31:0]));
        end
        chk(cmd_ready_o == 1'b0 && busy_o == 1'b1, "busy_while_valid",
            64'({cmd_ready_o, busy_o}), 64'b01);
        if (res_ready_i) hs_pend = 1'b1;
      end
      prev_valid = res_valid_o;
    end
  end

  // ---------------- driver ----------------
  // done_at: poll number that returns done (0 = never); exp_to: expect timeout;
  // hold: cycles res_ready_i stays low; poke: pulse cmd_valid_i in POLL_WAIT;
  // rst_reads: if >0, assert reset after that many result reads.
  task automatic run_test(input logic [31:0] p1, p2, p3, input int done_at,
                          input logic [31:0] base, input bit exp_to, input int hold,
                          input bit poke, input int rst_reads);
    int a, pd, n, nr, w;
    logic [319:0] d;
    @(negedge clk_sys_i);
    w = 0;
    while (!cmd_ready_o && w < 100) begin @(negedge clk_sys_i); w++; end
    if (!cmd_ready_o) begin
      chk(1'b0, "cmd_ready_wait", 64'(cmd_ready_o), 64'd1);
      return;
    end
    done_at_cfg = done_at;
    base_cfg    = base;
    cmd_param_i = {p3, p2, p1};
    cmd_valid_i = 1'b1;
    a = cyc + 1;
    bus_q.push_back(bus_e(1'b1, 4'd1, p1, a));
    bus_q.push_back(bus_e(1'b1, 4'd2, p2, a + 1));
    bus_q.push_back(bus_e(1'b1, 4'd3, p3, a + 2));
    bus_q.push_back(bus_e(1'b1, 4'd0, 32'h1, a + 3));
    n = exp_to ? TP : done_at;
    for (int k = 0; k < n; k++)
      bus_q.push_back(bus_e(1'b0, 4'd4, 32'h0, a + 4 + G + k * (G + 2)));
    pd = a + 4 + G + (n - 1) * (G + 2);
    nr = (rst_reads > 0) ? rst_reads : 10;
    if (!exp_to)
      for (int i = 0; i < nr; i++)
        bus_q.push_back(bus_e(1'b0, 4'(5 + i), 32'h0, pd + 2 + i));
    if (rst_reads == 0) begin
      d = '0;
      if (!exp_to) for (int i = 0; i < 10; i++) d[32*i +: 32] = base + 32'(i);
      exp_q.push_back({exp_to, d, 32'(exp_to ? pd + 2 : pd + 13)});
    end
    @(posedge clk_sys_i);
    #1 cmd_valid_i = 1'b0;

    if (poke) begin
      while (cyc < a + 5) @(negedge clk_sys_i);
      cmd_valid_i = 1'b1;
      chk(cmd_ready_o == 1'b0, "busy_reject_ready", 64'(cmd_ready_o), 64'd0);
      @(posedge clk_sys_i);
      #1 cmd_valid_i = 1'b0;
    end

    if (rst_reads > 0) begin
      do begin @(posedge clk_sys_i); #1; end while (cyc < pd + 2 + nr);
      rst_i = 1'b1;
      @(negedge clk_sys_i);
      chk(!avm_read_o && !avm_write_o, "rst_strobes_low",
          64'({avm_read_o, avm_write_o}), 64'd0);
      chk(cmd_ready_o == 1'b1, "rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk(res_valid_o == 1'b0 && busy_o == 1'b0, "rst_valid_busy",
          64'({res_valid_o, busy_o}), 64'd0);
      @(posedge clk_sys_i);
      #1 rst_i = 1'b0;
      chk(bus_q.size() == 0, "rst_bus_drained", 64'(bus_q.size()), 64'd0);
      return;
    end

    w = 0;
    while (!res_valid_o && w < 2000) begin @(negedge clk_sys_i); w++; end
    if (!res_valid_o) begin
      chk(1'b0, "res_valid_wait", 64'(res_valid_o), 64'd1);
      bus_q.delete();
      exp_q.delete();
      return;
    end
    repeat (hold) @(posedge clk_sys_i);
    #1 res_ready_i = 1'b1;
    @(posedge clk_sys_i);
    #1 res_ready_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk_sys_i);
    chk(cmd_ready_o == 1'b1 && busy_o == 1'b0 && res_valid_o == 1'b0, "reset_status",
        64'({cmd_ready_o, busy_o, res_valid_o}), 64'b100);
    chk(!avm_read_o && !avm_write_o && avm_address_o == 4'd0 && avm_writedata_o == 32'd0,
        "reset_bus", 64'({avm_read_o, avm_write_o, avm_address_o}), 64'd0);
    chk(res_data_o == '0 && res_timeout_o == 1'b0, "reset_result",
        64'(res_data_o[0]), 64'd0);
    @(posedge clk_sys_i);
    #1 rst_i = 1'b0;

    // nominal: done on first poll
    run_test(32'h11, 32'h22, 32'h33, 1, 32'hA0, 1'b0, 0, 1'b0, 0);
    // slow: done on 5th poll, short hold
    run_test(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 5, 32'hB000_0000, 1'b0, 2, 1'b0, 0);
    // backpressure: ready low 20 cycles
    run_test(32'hFFFF_FFFF, 32'h0, 32'h8000_0001, 1, 32'hC0, 1'b0, 20, 1'b0, 0);
    // busy rejection during POLL_WAIT
    run_test(32'h44, 32'h55, 32'h66, 2, 32'hD0, 1'b0, 0, 1'b1, 0);
    // reset after three result reads
    run_test(32'h77, 32'h88, 32'h99, 1, 32'hE0, 1'b0, 0, 1'b0, 3);
    // nominal again after reset
    run_test(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1, 32'hF0, 1'b0, 1, 1'b0, 0);
`ifdef CSR_SEQ_TIMEOUT_EN
    // done never set: abort after TP polls
    run_test(32'h1, 32'h2, 32'h3, 0, 32'h0, 1'b1, 0, 1'b0, 0);
    run_test(32'hAA, 32'hBB, 32'hCC, 1, 32'h500, 1'b0, 0, 1'b0, 0);
`endif

    repeat (4) @(negedge clk_sys_i);
    chk(bus_q.size() == 0, "bus_queue_empty", 64'(bus_q.size()), 64'd0);
    chk(exp_q.size() == 0, "res_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
